dpram_tdp: RTL
==============

Name: dpram_tdp

Overview:
Parametrised true dual-port synchronous RAM. Either port can read or write. This is the successor to the fixed 8x16 single-write/single-read dual-port RAM. It adds a per-port write enable, registered read-valid strobes, a defined same-address collision policy and a reset-driven memory clear sequencer. It is used as the shared buffer between two independent requesters in one clock domain.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 16, number of words; power of two, at least 2
ADDR_W, $clog2(DEPTH), address width; derived, not overridden
WRITE_MODE, 0, same-port read-during-write result: 0 = read-first (old data), 1 = write-first (new data)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous active-high reset
port_enable_0  input  1  port 0 access request
wr_en_0  input  1  port 0 write (1) / read (0); ignored when port_enable_0=0
address_in_0  input  ADDR_W  port 0 address
din_0  input  DATA_W  port 0 write data
dout0  output  DATA_W  port 0 read data (registered)
dout_valid_0  output  1  dout0 holds a new read result
port_enable_1, wr_en_1, address_in_1, din_1, dout1, dout_valid_1: port 1 equivalents
busy  output  1  clear sequence active; port requests ignored
collision  output  1  one-cycle pulse: both ports enabled on the same address with at least one writing

Behaviour:
- Reset (rst=1 at edge): dout0=0, dout1=0, dout_valid_*=0, collision=0, busy=1, clear pointer=0, FSM moves to CLEAR. Applies at any time, including mid-clear; asserting rst mid-clear restarts the clear from address 0.
- FSM CLEAR: one word per cycle, mem[ptr]=0, ptr increments. After writing DEPTH-1 the FSM goes to READY next cycle.
- busy is high for exactly DEPTH cycles after rst deasserts. During CLEAR all port inputs are ignored and dout_valid_*=0.
- FSM READY: busy=0. There is no other exit; only rst returns the FSM to CLEAR.
- Read, port p (enable=1, wr_en=0): doutp=mem[addr] on the next edge (latency 1); dout_valid_p=1 for that one cycle.
- Write, port p (enable=1, wr_en=1): mem[addr]=din on the edge.
  - WRITE_MODE=0: doutp gets the old word.
  - WRITE_MODE=1: doutp gets din.
  - dout_valid_p=1 on the following cycle in both modes.
- Idle port (enable=0): doutp holds its last value; dout_valid_p=0.
- Collision (both ports enabled, same address):
  - Both writing: port 0 data is stored and port 1 data is dropped.
  - One writing, the other reading: the reader gets the old word (read-first across ports, regardless of WRITE_MODE).
  - Both reading: same data to both, collision=0.
  - collision=1 for one cycle, aligned with dout_valid.
- Different addresses: fully independent, no interaction.
- Address wrap: addresses are naturally ADDR_W wide, so no out-of-range access is possible.

Optional Feature:
DPRAM_OUTREG_EN defined:
- An extra output pipeline register on doutp, dout_valid_p and collision.
- Read latency 2; reset value 0 for all added registers.
- A read issued in the last CLEAR cycle is still ignored.

DPRAM_OUTREG_EN undefined: latency 1 as specified above.

Decomposition:
- Package dpram_pkg holds:
  - state typedef (CLEAR, READY)
  - WRITE_MODE encodings READ_FIRST=0 and WRITE_FIRST=1
- Sub-module dpram_port_rd handles one port's output path: read/write mux, valid strobe, optional output register. It is instantiated twice.
- The memory array, collision logic and clear FSM stay in the top level.

Test Plan:
- Clear: assert rst 1 cycle with DEPTH=16 -> busy high exactly 16 cycles. Then a read of addresses 0..15 on both ports returns 0x00 with dout_valid pulsing 1 cycle after each request.
- Port 0 writes i+1 to address i for i=0..15, then port 1 reads 0..15 -> dout1 = 0x01..0x10 at latency 1 (2 with DPRAM_OUTREG_EN).
- Simultaneous writes to address 5: port 0 writes 0xAA, port 1 writes 0x55 -> collision pulses once; a later read of address 5 returns 0xAA.
- Write address 3 = 0x11, then write 0x22 while port 0 reads back address 3 -> dout0=0x11 when WRITE_MODE=0, 0x22 when WRITE_MODE=1. Port 1 reading address 3 in the same cycle gets 0x11 in both modes.
- Assert rst mid-clear at cycle 7 -> busy stays high for 16 more cycles after release, and writes attempted during busy are not stored.
- Concurrent traffic on distinct addresses: port 0 writes 0x3C to address 2 while port 1 reads address 9 (holding 0x0A) -> dout1=0x0A, collision=0.

Source files
------------

// File: rtl/dpram_pkg.sv
// -----------------------------------------------------------------------------
// dpram_pkg
// Shared types and constants for the dpram_tdp true dual-port RAM.
//   state_e     : clear-sequencer states (ST_CLEAR, ST_READY)
//   READ_FIRST  : WRITE_MODE encoding, a writing port returns the old word
//   WRITE_FIRST : WRITE_MODE encoding, a writing port returns its write data
// -----------------------------------------------------------------------------
package dpram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int READ_FIRST  = 0;
  localparam int WRITE_FIRST = 1;

endpackage : dpram_pkg

// File: rtl/dpram_port_rd.sv
// -----------------------------------------------------------------------------
// dpram_port_rd
// Output path of one RAM port: selects the word returned for an accepted
// access (the stored word, or the write data for a write-first port), raises
// a one-cycle valid strobe and holds the data while the port is idle.
// Optional macro DPRAM_OUTREG_EN adds a second register stage on data and
// valid (latency 2, reset to 0).
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   acc_i        : access accepted this cycle (enabled and RAM ready)
//   wr_i         : accepted access is a write
//   rd_word_i    : word currently stored at the access address (pre-write)
//   wdata_i      : write data of this port
//   dout_o       : registered read data
//   dout_valid_o : one-cycle strobe, dout_o holds a new result
// -----------------------------------------------------------------------------
module dpram_port_rd
  import dpram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int WRITE_MODE = READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o
);

  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dout_d  = dout_q;
    valid_d = acc_i;
    if (acc_i) begin
      if (wr_i && (WRITE_MODE == WRITE_FIRST)) dout_d = wdata_i;
      else                                     dout_d = rd_word_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] dout2_q;
  logic              valid2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout2_q  <= '0;
      valid2_q <= 1'b0;
    end else begin
      dout2_q  <= dout_q;
      valid2_q <= valid_q;
    end
  end

  assign dout_o       = dout2_q;
  assign dout_valid_o = valid2_q;
`else
  assign dout_o       = dout_q;
  assign dout_valid_o = valid_q;
`endif

endmodule : dpram_port_rd

// File: rtl/dpram_tdp.sv
// -----------------------------------------------------------------------------
// dpram_tdp
// Parametrised true dual-port synchronous RAM, single clock domain. After
// reset a sequencer clears one word per cycle (busy high, requests ignored),
// then the RAM serves both ports. Same-address collisions: port 0 wins a
// double write; a reader always sees the old word; collision pulses when at
// least one of the two colliding ports writes.
// Optional macro DPRAM_OUTREG_EN adds an output register stage on dout*,
// dout_valid_* and collision (read latency 2).
//
// Ports:
//   clk, rst                 : clock; synchronous active-high reset
//   port_enable_p, wr_en_p   : port p request and write select
//   address_in_p, din_p      : port p address and write data
//   dout<p>, dout_valid_p    : port p registered read data and valid strobe
//   busy                     : clear sequence in progress
//   collision                : same-address access with at least one write
// -----------------------------------------------------------------------------
module dpram_tdp
  import dpram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int WRITE_MODE = READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              port_enable_0,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] address_in_0,
  input  logic [DATA_W-1:0] din_0,
  output logic [DATA_W-1:0] dout0,
  output logic              dout_valid_0,
  input  logic              port_enable_1,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] address_in_1,
  input  logic [DATA_W-1:0] din_1,
  output logic [DATA_W-1:0] dout1,
  output logic              dout_valid_1,
  output logic              busy,
  output logic              collision
);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              coll_q, coll_d;

  logic              ready;
  logic              acc_0, acc_1;
  logic              wr_0, wr_1;
  logic [DATA_W-1:0] rd_word_0, rd_word_1;

  // Requests are accepted only once the clear has finished; a request in the
  // last clear cycle is therefore dropped.
  assign ready = (state_q == ST_READY) && !rst;
  assign acc_0 = ready && port_enable_0;
  assign acc_1 = ready && port_enable_1;
  assign wr_0  = acc_0 && wr_en_0;
  assign wr_1  = acc_1 && wr_en_1;

  // Pre-edge contents: both ports see the old word on a same-address write.
  assign rd_word_0 = mem[address_in_0];
  assign rd_word_1 = mem[address_in_1];

  assign busy = (state_q == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = ST_READY;
      end
      ST_READY: ;
      default:  state_d = ST_CLEAR;
    endcase
  end

  assign coll_d = acc_0 && acc_1 && (address_in_0 == address_in_1) &&
                  (wr_en_0 || wr_en_1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coll_q  <= coll_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch so it maps onto RAM macros; its
  // contents are zeroed by the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == ST_CLEAR)) begin
      mem[ptr_q] <= '0;
    end else begin
      // Port 0 is written last so it wins a same-address double write.
      if (wr_1) mem[address_in_1] <= din_1;
      if (wr_0) mem[address_in_0] <= din_0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output paths
  // ---------------------------------------------------------------------------
  dpram_port_rd #(
    .DATA_W     (DATA_W),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_rd_0 (
    .clk          (clk),
    .rst          (rst),
    .acc_i        (acc_0),
    .wr_i         (wr_en_0),
    .rd_word_i    (rd_word_0),
    .wdata_i      (din_0),
    .dout_o       (dout0),
    .dout_valid_o (dout_valid_0)
  );

  dpram_port_rd #(
    .DATA_W     (DATA_W),
    .WRITE_MODE (WRITE_MODE)
  ) u_port_rd_1 (
    .clk          (clk),
    .rst          (rst),
    .acc_i        (acc_1),
    .wr_i         (wr_en_1),
    .rd_word_i    (rd_word_1),
    .wdata_i      (din_1),
    .dout_o       (dout1),
    .dout_valid_o (dout_valid_1)
  );

`ifdef DPRAM_OUTREG_EN
  logic coll2_q;

  always_ff @(posedge clk) begin
    if (rst) coll2_q <= 1'b0;
    else     coll2_q <= coll_q;
  end

  assign collision = coll2_q;
`else
  assign collision = coll_q;
`endif

endmodule : dpram_tdp
